// File: rtl/ex_mul_div_pkg.sv
// Shared constants, funct3 encodings and state type for the EX-stage mul/div unit.
package ex_mul_div_pkg;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned CNT_W = 7;
   localparam int unsigned WLEN  = 32;

   // RV M-extension funct3 encodings
   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   // Final counter value for a full-width and a word-width operation
   localparam logic [CNT_W-1:0] LAST_D = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] LAST_W = CNT_W'(WLEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } md_state_e;

   // Sign-extend the low word to XLEN
   function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
      return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
   endfunction

   // Zero-extend the low word to XLEN
   function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
      return {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
   endfunction

endpackage

// File: rtl/ex_mul_div_divider.sv
// Restoring divider core: one quotient bit per cycle on magnitudes, sign fixup on outputs.
// done_c/quotient_c/remainder_c reflect the final iteration in the cycle it executes,
// so the caller can register the result on the same edge.
module md_divider
   import ex_mul_div_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            word,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            neg_q,
   input  logic            neg_r,
   output logic            done_c,
   output logic [XLEN-1:0] quotient_c,
   output logic [XLEN-1:0] remainder_c
);

   logic             busy;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last_q;
   logic [XLEN-1:0]  dq;      // dividend bits shift out the top, quotient bits shift in the bottom
   logic [XLEN-1:0]  rem;
   logic [XLEN-1:0]  dsr;
   logic             nq;
   logic             nr;

   logic [XLEN:0]    r_shift_c;
   logic [XLEN:0]    diff_c;
   logic             ge_c;
   logic [XLEN-1:0]  rem_step_c;
   logic [XLEN-1:0]  quot_step_c;

   // One restoring step plus sign fixup of the stepped values
   always_comb begin
      r_shift_c   = {rem, dq[XLEN-1]};
      diff_c      = r_shift_c - {1'b0, dsr};
      ge_c        = ~diff_c[XLEN];
      rem_step_c  = ge_c ? diff_c[XLEN-1:0] : r_shift_c[XLEN-1:0];
      quot_step_c = {dq[XLEN-2:0], ge_c};
      done_c      = busy & (cnt == last_q);
      quotient_c  = nq ? -quot_step_c : quot_step_c;
      remainder_c = nr ? -rem_step_c  : rem_step_c;
   end

   // Operand capture and iteration; word dividends are pre-aligned to the top
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         last_q <= '0;
         dq     <= '0;
         rem    <= '0;
         dsr    <= '0;
         nq     <= 1'b0;
         nr     <= 1'b0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         last_q <= word ? LAST_W : LAST_D;
         dq     <= word ? {dividend[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : dividend;
         rem    <= '0;
         dsr    <= divisor;
         nq     <= neg_q;
         nr     <= neg_r;
      end else if (busy) begin
         dq   <= quot_step_c;
         rem  <= rem_step_c;
         cnt  <= cnt + CNT_W'(1);
         busy <= ~done_c;
      end
   end

endmodule

// File: rtl/ex_mul_div.sv
// Iterative RV64M multiply/divide unit for the EX stage with pipeline stall request.
module ex_mul_div
   import ex_mul_div_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [2:0]      funct3_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   input  logic            flush_i,
   input  logic            hold_i,
   output logic            stall_req_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned PW = 2 * XLEN;
   localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

   md_state_e        state;
   md_state_e        state_nxt;

   logic [2:0]       op_q;
   logic             word_q;
   logic             neg_p_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last_q;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [XLEN-1:0]  mplier;

   logic             a_signed_c, b_signed_c, a_neg_c, b_neg_c;
   logic             is_div_c, is_rem_c, div_zero_c, div_ovf_c;
   logic [XLEN-1:0]  a_ext_c, b_ext_c, a_mag_c, b_mag_c, fast_res_c;

   logic [PW-1:0]    acc_step_c;
   logic [PW-1:0]    prod_c;
   logic [XLEN-1:0]  mul_res_c;
   logic [XLEN-1:0]  div_res_c;

   logic             div_done_c;
   logic [XLEN-1:0]  div_quot_c;
   logic [XLEN-1:0]  div_rem_c;

   logic             start_mul_c;
   logic             start_div_c;
   logic             load_res_c;
   logic [XLEN-1:0]  res_nxt_c;

   assign stall_req_o = valid_i & ~flush_i & (state != DONE);

   // Operand decode: word extension, magnitudes and fast-path results
   always_comb begin
      a_signed_c = (funct3_i == MD_MULH) | (funct3_i == MD_MULHSU) |
                   (funct3_i == MD_DIV)  | (funct3_i == MD_REM);
      b_signed_c = (funct3_i == MD_MULH) | (funct3_i == MD_DIV) | (funct3_i == MD_REM);
      is_div_c   = (funct3_i == MD_DIV) | (funct3_i == MD_DIVU) |
                   (funct3_i == MD_REM) | (funct3_i == MD_REMU);
      is_rem_c   = (funct3_i == MD_REM) | (funct3_i == MD_REMU);
      a_ext_c    = word_i ? (a_signed_c ? sext_w(src1_i) : zext_w(src1_i)) : src1_i;
      b_ext_c    = word_i ? (b_signed_c ? sext_w(src2_i) : zext_w(src2_i)) : src2_i;
      a_neg_c    = a_signed_c & a_ext_c[XLEN-1];
      b_neg_c    = b_signed_c & b_ext_c[XLEN-1];
      a_mag_c    = a_neg_c ? -a_ext_c : a_ext_c;
      b_mag_c    = b_neg_c ? -b_ext_c : b_ext_c;
      div_zero_c = is_div_c & (b_ext_c == '0);
      div_ovf_c  = ((funct3_i == MD_DIV) | (funct3_i == MD_REM)) &
                   (a_ext_c == (word_i ? MIN_W : MIN_D)) & (b_ext_c == '1);
      if (div_zero_c)
         fast_res_c = is_rem_c ? a_ext_c : '1;
      else
         fast_res_c = is_rem_c ? '0 : a_ext_c;
      if (word_i)
         fast_res_c = sext_w(fast_res_c);
   end

   // Multiplier step and final result selection for both datapaths
   always_comb begin
      acc_step_c = mplier[0] ? (acc + mcand) : acc;
      prod_c     = neg_p_q ? -acc_step_c : acc_step_c;
      mul_res_c  = (op_q == MD_MUL) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
      div_res_c  = ((op_q == MD_REM) | (op_q == MD_REMU)) ? div_rem_c : div_quot_c;
      if (word_q) begin
         mul_res_c = sext_w(mul_res_c);
         div_res_c = sext_w(div_res_c);
      end
   end

   md_divider u_div (
      .clk         (clk),
      .rst         (rst),
      .start       (start_div_c),
      .abort       (flush_i),
      .word        (word_i),
      .dividend    (a_mag_c),
      .divisor     (b_mag_c),
      .neg_q       (a_neg_c ^ b_neg_c),
      .neg_r       (a_neg_c),
      .done_c      (div_done_c),
      .quotient_c  (div_quot_c),
      .remainder_c (div_rem_c)
   );

   // Next-state logic and datapath control; flush overrides everything
   always_comb begin
      state_nxt   = state;
      start_mul_c = 1'b0;
      start_div_c = 1'b0;
      load_res_c  = 1'b0;
      res_nxt_c   = mul_res_c;
      case (state)
         IDLE: begin
            if (valid_i) begin
               if (div_zero_c | div_ovf_c) begin
                  state_nxt  = DONE;
                  load_res_c = 1'b1;
                  res_nxt_c  = fast_res_c;
               end else if (is_div_c) begin
                  state_nxt   = DIV;
                  start_div_c = 1'b1;
               end else begin
                  state_nxt   = MUL;
                  start_mul_c = 1'b1;
               end
            end
         end
         MUL: begin
            if (cnt == last_q) begin
               state_nxt  = DONE;
               load_res_c = 1'b1;
               res_nxt_c  = mul_res_c;
            end
         end
         DIV: begin
            if (div_done_c) begin
               state_nxt  = DONE;
               load_res_c = 1'b1;
               res_nxt_c  = div_res_c;
            end
         end
         DONE: begin
            if (!hold_i)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush_i) begin
         state_nxt   = IDLE;
         start_mul_c = 1'b0;
         start_div_c = 1'b0;
         load_res_c  = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Operand latch, shift-add multiplier loop and registered result
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q           <= '0;
         word_q         <= 1'b0;
         neg_p_q        <= 1'b0;
         cnt            <= '0;
         last_q         <= '0;
         acc            <= '0;
         mcand          <= '0;
         mplier         <= '0;
         result_valid_o <= 1'b0;
         result_o       <= '0;
      end else begin
         if (flush_i) begin
            cnt <= '0;
         end else if (start_mul_c) begin
            cnt    <= '0;
            last_q <= word_i ? LAST_W : LAST_D;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag_c};
            mplier <= b_mag_c;
         end else if (state == MUL) begin
            acc    <= acc_step_c;
            mcand  <= {mcand[PW-2:0], 1'b0};
            mplier <= {1'b0, mplier[XLEN-1:1]};
            cnt    <= cnt + CNT_W'(1);
         end
         if ((state == IDLE) & valid_i & ~flush_i) begin
            op_q    <= funct3_i;
            word_q  <= word_i;
            neg_p_q <= a_neg_c ^ b_neg_c;
         end
         if (load_res_c)
            result_o <= res_nxt_c;
         result_valid_o <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_ex_mul_div.sv
// Directed self-checking bench for ex_mul_div.
module tb_ex_mul_div;
   import ex_mul_div_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            valid_i;
   logic [2:0]      funct3_i;
   logic            word_i;
   logic [XLEN-1:0] src1_i;
   logic [XLEN-1:0] src2_i;
   logic            flush_i;
   logic            hold_i;
   logic            stall_req_o;
   logic            result_valid_o;
   logic [XLEN-1:0] result_o;

   int n_checks = 0;
   int n_errors = 0;

   ex_mul_div dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .funct3_i       (funct3_i),
      .word_i         (word_i),
      .src1_i         (src1_i),
      .src2_i         (src2_i),
      .flush_i        (flush_i),
      .hold_i         (hold_i),
      .stall_req_o    (stall_req_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op at cycle T, hold valid_i until completion, optionally hold DONE
   task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat_exp, input int hold_n);
      int   lat;
      logic got;
      logic stall_ok;
      @(negedge clk);
      funct3_i = f3;
      word_i   = w;
      src1_i   = a;
      src2_i   = b;
      valid_i  = 1'b1;
      #1;
      check({tag, " stall_T"}, 64'(stall_req_o), 64'd1);
      lat      = 0;
      got      = 1'b0;
      stall_ok = 1'b1;
      while (!got && lat < 200) begin
         @(negedge clk);
         lat++;
         src1_i = {$urandom, $urandom};
         src2_i = {$urandom, $urandom};
         #1;
         if (result_valid_o)
            got = 1'b1;
         else if (!stall_req_o)
            stall_ok = 1'b0;
      end
      check({tag, " latency"}, 64'(lat), 64'(lat_exp));
      check({tag, " stall_busy"}, 64'(stall_ok), 64'd1);
      check({tag, " result"}, result_o, exp);
      check({tag, " stall_done"}, 64'(stall_req_o), 64'd0);
      if (hold_n > 0)
         hold_i = 1'b1;
      else
         valid_i = 1'b0;
      for (int i = 1; i <= hold_n; i++) begin
         @(negedge clk);
         #1;
         check({tag, " hold_valid"}, 64'(result_valid_o), 64'd1);
         check({tag, " hold_result"}, result_o, exp);
         check({tag, " hold_stall"}, 64'(stall_req_o), 64'd0);
         if (i == hold_n) begin
            hold_i  = 1'b0;
            valid_i = 1'b0;
         end
      end
      @(negedge clk);
      #1;
      check({tag, " single"}, 64'(result_valid_o), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rv_seen;
      rst      = 1'b1;
      valid_i  = 1'b0;
      funct3_i = MD_MUL;
      word_i   = 1'b0;
      src1_i   = '0;
      src2_i   = '0;
      flush_i  = 1'b0;
      hold_i   = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset result_valid", 64'(result_valid_o), 64'd0);
      check("reset result", result_o, 64'd0);
      check("reset stall", 64'(stall_req_o), 64'd0);
      rst = 1'b0;

      run_op("MUL 7*-3",      MD_MUL,    1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 65, 0);
      run_op("MULHU",         MD_MULHU,  1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'h0000000000000001, 65, 0);
      run_op("MULH",          MD_MULH,   1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65, 0);
      run_op("MULHSU",        MD_MULHSU, 1'b0, 64'h8000000000000000, 64'd4, 64'hFFFFFFFFFFFFFFFE, 65, 0);
      run_op("DIV -7/2",      MD_DIV,    1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65, 0);
      run_op("REM -7/2",      MD_REM,    1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65, 0);
      run_op("DIVUW",         MD_DIVU,   1'b1, 64'h0000000080000000, 64'd1, 64'hFFFFFFFF80000000, 33, 0);
      run_op("MULW",          MD_MUL,    1'b1, 64'h123456787FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 33, 0);
      run_op("REMW",          MD_REM,    1'b1, 64'hAAAAAAAAFFFFFFF9, 64'h5555555500000003, 64'hFFFFFFFFFFFFFFFF, 33, 0);
      run_op("DIV x/0",       MD_DIV,    1'b0, 64'd100, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1, 0);
      run_op("REMU 5/0",      MD_REMU,   1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
      run_op("DIV ovf",       MD_DIV,    1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1, 0);
      run_op("REM ovf",       MD_REM,    1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 0);
      run_op("DIVW ovf",      MD_DIV,    1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1, 0);
      run_op("DIVU 100/7",    MD_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65, 0);

      // Flush a DIV at T+10, then issue MUL 3*4 at T+12
      @(negedge clk);
      funct3_i = MD_DIV;
      word_i   = 1'b0;
      src1_i   = 64'd100;
      src2_i   = 64'd7;
      valid_i  = 1'b1;
      rv_seen  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         #1;
         if (result_valid_o) rv_seen = 1'b1;
      end
      flush_i = 1'b1;
      #1;
      check("flush stall", 64'(stall_req_o), 64'd0);
      @(negedge clk);
      flush_i = 1'b0;
      valid_i = 1'b0;
      #1;
      if (result_valid_o) rv_seen = 1'b1;
      check("flush no result", 64'(rv_seen), 64'd0);
      run_op("MUL after flush", MD_MUL, 1'b0, 64'd3, 64'd4, 64'd12, 65, 0);

      // DONE held by hold_i for three cycles
      run_op("REMU hold",     MD_REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65, 3);

      // Reset mid-operation clears the result register
      @(negedge clk);
      funct3_i = MD_MUL;
      src1_i   = 64'd9;
      src2_i   = 64'd9;
      valid_i  = 1'b1;
      repeat (5) @(negedge clk);
      rst     = 1'b1;
      valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midop reset result", result_o, 64'd0);
      check("midop reset valid", 64'(result_valid_o), 64'd0);
      run_op("MUL after reset", MD_MULHU, 1'b0, 64'h8000000000000000, 64'd6, 64'd3, 65, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_mul_div.md
Name: ex_mul_div

Overview:
Iterative RV64M multiply/divide unit in the EX stage. It latches operands from ID_EX, runs a shift-add multiplier or a restoring divider over several cycles, and returns the XLEN result to the EX result mux. While it is busy it raises the mul/div stall request consumed by the pipeline hazard controller. That controller responds by stalling PC, Pre_IF and IF_ID and flushing EX_MEM, so no bubble-free result leaks downstream.

Parameters:
XLEN, 64, datapath width.
CNT_W, 7, iteration counter width (must hold XLEN).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
valid_i  in  1  EX holds a mul/div instruction this cycle
funct3_i  in  3  RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
word_i  in  1  *W variant (MULW/DIVW/DIVUW/REMW/REMUW)
src1_i  in  XLEN  rs1 value
src2_i  in  XLEN  rs2 value
flush_i  in  1  EX kill (trap/jump flush of ID_EX); aborts the operation
hold_i  in  1  downstream stall (EX_MEM stalled, e.g. mem RAM wait)
stall_req_o  out  1  to pipeline control alu_mul_div_valid_ex_i
result_valid_o  out  1  result_o is valid
result_o  out  XLEN  final result

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. On reset: state IDLE, counter 0, stall_req_o 0, result_valid_o 0, result_o 0, all internal registers 0.
- States: IDLE, MUL, DIV, DONE.
- stall_req_o = valid_i & ~flush_i & (state != DONE). It is combinational and is asserted in the same cycle the instruction arrives.
- IDLE, with valid_i & ~flush_i at cycle T:
  - Latch operands. For word_i, use the low 32 bits: sign-extended for signed ops, zero-extended for unsigned ops.
  - Iteration count N = 32 if word_i, else XLEN.
  - Divide by zero (divisor == 0): go to DONE. Quotient = all ones; remainder = dividend (after word extension).
  - Signed overflow (DIV/REM with dividend = most-negative, divisor = -1, at the operating width): go to DONE. Quotient = dividend; remainder = 0.
  - Otherwise go to MUL (funct3 < 4) or DIV (funct3 >= 4).
- MUL:
  - Operands are held as magnitudes; sign fixup is applied in DONE.
  - Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned; MUL/MULW use the low bits only.
  - Each cycle, add the shifted multiplicand into a 2×XLEN accumulator when the current multiplier LSB is 1, then shift. Counter increments.
  - After N iterations go to DONE.
- DIV:
  - Restoring, one quotient bit per cycle on magnitudes.
  - Quotient is negated if the operand signs differ (signed ops only). Remainder takes the dividend's sign.
  - After N iterations go to DONE.
- Latency: DONE is reached at T+N+1 (T+1 for fast paths).
- DONE:
  - result_valid_o = 1 and stall_req_o = 0, so the pipeline advances.
  - Result selection: MUL → product[XLEN-1:0]; MULH* → product[2XLEN-1:XLEN]; DIV* → quotient; REM* → remainder.
  - word_i → result is sign-extended bits [31:0], for all W ops including DIVUW/REMUW.
  - The next cycle goes to IDLE, unless hold_i = 1, in which case it stays in DONE with the result stable.
  - DONE never restarts on the same valid_i. A new operation is accepted only from IDLE.
- result_o is registered and retains its value outside DONE. result_valid_o is 0 outside DONE.
- flush_i in any state: go to IDLE next cycle, result_valid_o 0, counter cleared. stall_req_o is forced 0 in that cycle.
- Simultaneous flush_i and valid_i in IDLE: flush wins and nothing is started.
- Reset mid-operation behaves like flush, and additionally clears result_o.
- Operands on src*_i may change after T. The unit uses only the latched copies.

Decomposition:
- The funct3 encodings (MD_MUL … MD_REMU) and the state encodings go in the shared sysconfig.v define set. No local magic numbers.
- One sub-module, md_divider: restoring divider core with start/done, magnitude inputs and sign-fixup outputs.
- The multiplier loop, state machine and result mux stay in ex_mul_div.

Test Plan:
- MUL 7×(-3), word_i=0 → stall_req_o high for 65 cycles from T; result 0xFFFFFFFFFFFFFFEB, result_valid_o at T+65 for 1 cycle.
- MULHU 0xFFFFFFFFFFFFFFFF×2 → 0x0000000000000001; MULH same operands → 0xFFFFFFFFFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFFFFFFFFFD; REM -7/2 → 0xFFFFFFFFFFFFFFFF; DIVUW 0x80000000/1 → 0xFFFFFFFF80000000 at T+33.
- DIV x/0 → all ones at T+1; REMU 5/0 → 5; DIV 0x8000000000000000/-1 → 0x8000000000000000, REM → 0, both at T+1.
- flush_i asserted at T+10 of a DIV → IDLE at T+11, no result_valid_o; a new MUL 3×4 issued at T+12 → 12 at T+77.
- hold_i held 3 cycles while in DONE → result_o stable, stall_req_o 0, single completion, no restart; IDLE after hold_i drops.
